// File: rtl/berzerk_input_pkg.sv
// Shared constants and types for the berzerk control-input mapper: scancodes,
// HPS joystick bit positions, key-state record and the coin FSM state type.
package berzerk_input_pkg;

  // Arrow keys match on the low byte only, so extended and keypad codes both count.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_LCTRL = 9'h014;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_1     = 9'h016;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_2     = 9'h01E;
  localparam logic [8:0] SC_5     = 9'h02E;
  localparam logic [8:0] SC_6     = 9'h036;
  localparam logic [8:0] SC_R     = 9'h02D;
  localparam logic [8:0] SC_F     = 9'h02B;
  localparam logic [8:0] SC_D     = 9'h023;
  localparam logic [8:0] SC_G     = 9'h034;
  localparam logic [8:0] SC_A     = 9'h01C;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_WAIT_RELEASE
  } coin_state_e;

  typedef struct packed {
    logic up1, down1, left1, right1, fire1;
    logic start1, start2, coin_a, coin_b;
    logic up2, down2, left2, right2, fire2;
  } key_state_t;

  typedef struct packed {
    logic right, left, down, up, fire;
  } player_t;

  // Opposing-direction cancel: returns {a,b}, or 0 when both are set and en=1.
  function automatic logic [1:0] socd_pair(input logic a, input logic b, input logic en);
    return (en && a && b) ? 2'b00 : {a, b};
  endfunction

endpackage

// File: rtl/berzerk_coin_pulse.sv
// Coin shaper: one COIN_PULSE_CYCLES-long pulse per rising edge of raw coin,
// then waits for release so a held coin never repeats.
module berzerk_coin_pulse
  import berzerk_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 400000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic coin
);

  localparam logic [19:0] CNT_LOAD = 20'(COIN_PULSE_CYCLES - 1);

  coin_state_e state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        raw_q, coin_q, coin_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coin_d  = coin_q;
    case (state_q)
      COIN_IDLE: begin
        if (raw && !raw_q) begin
          state_d = COIN_PULSE;
          cnt_d   = CNT_LOAD;
          coin_d  = 1'b1;
        end
      end
      COIN_PULSE: begin
        // Edges seen here are ignored; the pulse length is fixed.
        if (cnt_q == '0) begin
          coin_d  = 1'b0;
          state_d = raw ? COIN_WAIT_RELEASE : COIN_IDLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      COIN_WAIT_RELEASE: begin
        if (!raw) state_d = COIN_IDLE;
      end
      default: state_d = COIN_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      raw_q   <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw;
      coin_q  <= coin_d;
    end
  end

  assign coin = coin_q;

endmodule

// File: rtl/berzerk_input_mapper.sv
// Maps HPS keyboard events and both HPS joysticks onto berzerk player controls,
// with cocktail routing, opposing-direction cancel and a shaped coin pulse.
// Optional AUTOFIRE_EN adds an autofire input and per-player fire toggling.
module berzerk_input_mapper
  import berzerk_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 400000,
  parameter bit SOCD_CANCEL       = 1'b1
`ifdef AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV      = 2000000
`endif
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        cocktail,
`ifdef AUTOFIRE_EN
  input  logic        autofire,
`endif
  output logic        right1,
  output logic        left1,
  output logic        down1,
  output logic        up1,
  output logic        fire1,
  output logic        right2,
  output logic        left2,
  output logic        down2,
  output logic        up2,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  key_state_t kb_q, kb_d;
  logic       tog_q, tog_d;
  player_t    p1_q, p1_d, p2_q, p2_d;
  logic       start1_q, start1_d, start2_q, start2_d;
  logic [7:0] joy_any, j1_src, j2_src;
  logic [1:0] held;
  logic [1:0] fire_d;
  logic       coin_raw;
  logic       unused_joy;

  assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

  // Key decode: only acts on a toggle of ps2_key[10].
  always_comb begin
    kb_d  = kb_q;
    tog_d = ps2_key[10];
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[7:0])
        SC_UP:    kb_d.up1    = ps2_key[9];
        SC_DOWN:  kb_d.down1  = ps2_key[9];
        SC_LEFT:  kb_d.left1  = ps2_key[9];
        SC_RIGHT: kb_d.right1 = ps2_key[9];
        default: ;
      endcase
      case (ps2_key[8:0])
        SC_SPACE, SC_LCTRL: kb_d.fire1  = ps2_key[9];
        SC_F1, SC_1:        kb_d.start1 = ps2_key[9];
        SC_F2, SC_2:        kb_d.start2 = ps2_key[9];
        SC_5:               kb_d.coin_a = ps2_key[9];
        SC_6:               kb_d.coin_b = ps2_key[9];
        SC_R:               kb_d.up2    = ps2_key[9];
        SC_F:               kb_d.down2  = ps2_key[9];
        SC_D:               kb_d.left2  = ps2_key[9];
        SC_G:               kb_d.right2 = ps2_key[9];
        SC_A:               kb_d.fire2  = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Outputs are built from next key state so a key event reaches the pins in one clock.
  always_comb begin
    joy_any = joystick_0[7:0] | joystick_1[7:0];
    j1_src  = cocktail ? joystick_0[7:0] : joy_any;
    j2_src  = cocktail ? joystick_1[7:0] : joy_any;

    p1_d = '0;
    p2_d = '0;
    {p1_d.up, p1_d.down}    = socd_pair(kb_d.up1 | j1_src[JOY_U], kb_d.down1 | j1_src[JOY_D], SOCD_CANCEL);
    {p1_d.left, p1_d.right} = socd_pair(kb_d.left1 | j1_src[JOY_L], kb_d.right1 | j1_src[JOY_R], SOCD_CANCEL);
    {p2_d.up, p2_d.down}    = socd_pair(kb_d.up2 | j2_src[JOY_U], kb_d.down2 | j2_src[JOY_D], SOCD_CANCEL);
    {p2_d.left, p2_d.right} = socd_pair(kb_d.left2 | j2_src[JOY_L], kb_d.right2 | j2_src[JOY_R], SOCD_CANCEL);

    held[0] = kb_d.fire1 | j1_src[JOY_FIRE];
    held[1] = kb_d.fire2 | j2_src[JOY_FIRE];
    p1_d.fire = fire_d[0];
    p2_d.fire = fire_d[1];

    start1_d = kb_d.start1 | joy_any[JOY_START1];
    start2_d = kb_d.start2 | joy_any[JOY_START2];
    coin_raw = kb_d.coin_a | kb_d.coin_b | joy_any[JOY_COIN];
  end

`ifdef AUTOFIRE_EN
  localparam logic [31:0] AF_LAST = 32'(AUTOFIRE_DIV - 1);

  logic [1:0][31:0] af_cnt_q, af_cnt_d;
  logic [1:0]       af_lvl_q, af_lvl_d, held_q;

  // Per-player divider: restarts high on the first held cycle, clears on release.
  always_comb begin
    af_cnt_d = af_cnt_q;
    af_lvl_d = af_lvl_q;
    fire_d   = '0;
    for (int p = 0; p < 2; p++) begin
      if (!held[p]) begin
        af_cnt_d[p] = '0;
        af_lvl_d[p] = 1'b0;
      end else if (!held_q[p]) begin
        af_cnt_d[p] = '0;
        af_lvl_d[p] = 1'b1;
      end else if (af_cnt_q[p] == AF_LAST) begin
        af_cnt_d[p] = '0;
        af_lvl_d[p] = ~af_lvl_q[p];
      end else begin
        af_cnt_d[p] = af_cnt_q[p] + 32'd1;
      end
      fire_d[p] = autofire ? af_lvl_d[p] : held[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q <= '0;
      af_lvl_q <= '0;
      held_q   <= '0;
    end else begin
      af_cnt_q <= af_cnt_d;
      af_lvl_q <= af_lvl_d;
      held_q   <= held;
    end
  end
`else
  assign fire_d = held;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      kb_q     <= '0;
      tog_q    <= ps2_key[10];
      p1_q     <= '0;
      p2_q     <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      kb_q     <= kb_d;
      tog_q    <= tog_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
    end
  end

  berzerk_coin_pulse #(
    .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .raw    (coin_raw),
    .coin   (coin1)
  );

  assign {right1, left1, down1, up1, fire1} = p1_q;
  assign {right2, left2, down2, up2, fire2} = p2_q;
  assign start1 = start1_q;
  assign start2 = start2_q;

endmodule
